// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise-control sequencer: state encodings and state width.
package cruise_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF     = 3'd0,
      ST_CRUISE  = 3'd1,
      ST_ACCEL   = 3'd2,
      ST_DECEL   = 3'd3,
      ST_STANDBY = 3'd4
   } state_t;

endpackage

// File: rtl/cruise_step_timer.sv
// Adjust-tick divider: counts enabled cycles and pulses tick on every TICK_DIV-th one.
module cruise_step_timer #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = enable && !clear && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cruise_speed_ctrl.sv
// Cruise-control sequencer: engage/suspend/resume FSM, saturating set-speed register
// adjusted by held accel/decel buttons, and registered throttle up/down requests.
module cruise_speed_ctrl
   import cruise_pkg::*;
#(
   parameter int SPEED_W   = 8,
   parameter int MIN_SPEED = 45,
   parameter int MAX_SPEED = 120,
   parameter int STEP      = 1,
   parameter int TICK_DIV  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cruise_on,
   input  logic               cruise_off,
   input  logic               brake,
   input  logic               accel,
   input  logic               decel,
   input  logic [SPEED_W-1:0] speed,
   output logic [STATE_W-1:0] state,
   output logic               cruise_active,
   output logic [SPEED_W-1:0] target_speed,
   output logic               target_valid,
   output logic               throttle_up,
   output logic               throttle_down
);

   localparam logic [SPEED_W-1:0] MIN_S  = SPEED_W'(MIN_SPEED);
   localparam logic [SPEED_W-1:0] MAX_S  = SPEED_W'(MAX_SPEED);
   localparam logic [SPEED_W:0]   MIN_X  = (SPEED_W+1)'(MIN_SPEED);
   localparam logic [SPEED_W:0]   MAX_X  = (SPEED_W+1)'(MAX_SPEED);
   localparam logic [SPEED_W:0]   STEP_X = (SPEED_W+1)'(STEP);

   state_t state_q, state_next;
   logic   engage, disengage;
   logic   want_up, want_down, adjusting, tick;
   logic   in_range;

   // The extra MSB catches carry past MAX and borrow below zero before clamping.
   function automatic logic [SPEED_W-1:0] sat_up(input logic [SPEED_W-1:0] t);
      logic [SPEED_W:0] s;
      s = {1'b0, t} + STEP_X;
      return (s > MAX_X) ? MAX_S : s[SPEED_W-1:0];
   endfunction

   function automatic logic [SPEED_W-1:0] sat_down(input logic [SPEED_W-1:0] t);
      logic [SPEED_W:0] d;
      d = {1'b0, t} - STEP_X;
      return (d[SPEED_W] || (d < MIN_X)) ? MIN_S : d[SPEED_W-1:0];
   endfunction

   assign want_up   = accel && !decel;
   assign want_down = decel && !accel;
   assign in_range  = (speed >= MIN_S) && (speed <= MAX_S);
   assign adjusting = !cruise_off && !brake &&
                      (((state_q == ST_ACCEL) && want_up) ||
                       ((state_q == ST_DECEL) && want_down));

   cruise_step_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_step_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (!adjusting),
      .enable (adjusting),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_next;
      end
   end

   always_comb begin
      state_next = state_q;
      engage     = 1'b0;
      disengage  = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (!cruise_off && !brake && cruise_on && in_range) begin
               state_next = ST_CRUISE;
               engage     = 1'b1;
            end
         end
         ST_CRUISE, ST_ACCEL, ST_DECEL: begin
            if (cruise_off) begin
               state_next = ST_OFF;
               disengage  = 1'b1;
            end else if (brake) begin
               state_next = ST_STANDBY;
            end else if (state_q == ST_CRUISE) begin
               if (want_up)        state_next = ST_ACCEL;
               else if (want_down) state_next = ST_DECEL;
            end else if ((state_q == ST_ACCEL) && !want_up) begin
               state_next = ST_CRUISE;
            end else if ((state_q == ST_DECEL) && !want_down) begin
               state_next = ST_CRUISE;
            end
         end
         ST_STANDBY: begin
            if (cruise_off) begin
               state_next = ST_OFF;
               disengage  = 1'b1;
            end else if (cruise_on) begin
               state_next = ST_CRUISE;
            end
         end
         default: begin
            state_next = ST_OFF;
            disengage  = 1'b1;
         end
      endcase
   end

   always_comb begin
      cruise_active = (state_q == ST_CRUISE) || (state_q == ST_ACCEL) ||
                      (state_q == ST_DECEL);
   end

   assign state = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         target_speed <= '0;
         target_valid <= 1'b0;
      end else if (disengage) begin
         target_speed <= '0;
         target_valid <= 1'b0;
      end else if (engage) begin
         target_speed <= speed;
         target_valid <= 1'b1;
      end else if (tick) begin
         target_speed <= (state_q == ST_ACCEL) ? sat_up(target_speed)
                                               : sat_down(target_speed);
      end
   end

   // Throttle requests look at the current state/target, so they trail any change by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         throttle_up   <= 1'b0;
         throttle_down <= 1'b0;
      end else begin
         throttle_up   <= cruise_active && (speed < target_speed);
         throttle_down <= cruise_active && (speed > target_speed);
      end
   end

endmodule

// File: tb/tb_cruise_speed_ctrl.sv
// Scoreboard bench for cruise_speed_ctrl: directed scenarios plus randomized button/speed
// sequences, checked cycle by cycle against a behavioural model of the controller.
module tb_cruise_speed_ctrl;

   localparam int SPEED_W   = 8;
   localparam int MIN_SPEED = 45;
   localparam int MAX_SPEED = 120;
   localparam int STEP      = 1;
   localparam int TICK_DIV  = 4;

   localparam int M_OFF = 0, M_CRUISE = 1, M_ACCEL = 2, M_DECEL = 3, M_STANDBY = 4;

   logic               clk = 1'b0;
   logic               reset, cruise_on, cruise_off, brake, accel, decel;
   logic [SPEED_W-1:0] speed;
   logic [2:0]         state;
   logic               cruise_active, target_valid, throttle_up, throttle_down;
   logic [SPEED_W-1:0] target_speed;

   always #5 clk = ~clk;

   cruise_speed_ctrl #(
      .SPEED_W   (SPEED_W),
      .MIN_SPEED (MIN_SPEED),
      .MAX_SPEED (MAX_SPEED),
      .STEP      (STEP),
      .TICK_DIV  (TICK_DIV)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cruise_on     (cruise_on),
      .cruise_off    (cruise_off),
      .brake         (brake),
      .accel         (accel),
      .decel         (decel),
      .speed         (speed),
      .state         (state),
      .cruise_active (cruise_active),
      .target_speed  (target_speed),
      .target_valid  (target_valid),
      .throttle_up   (throttle_up),
      .throttle_down (throttle_down)
   );

   typedef struct packed {
      logic [2:0]         st;
      logic               act;
      logic [SPEED_W-1:0] tgt;
      logic               vld;
      logic               up;
      logic               dn;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Behavioural model: mode, set speed, and cycles the adjust button has been held.
   int m_mode = M_OFF, m_target = 0, m_held = 0;
   bit m_valid = 0, m_up = 0, m_dn = 0;

   task automatic model_step(input bit r, input bit co, input bit cf, input bit br,
                             input bit ac, input bit dc, input int spd);
      bit active;
      if (r) begin
         m_mode = M_OFF; m_target = 0; m_valid = 0; m_up = 0; m_dn = 0; m_held = 0;
         return;
      end
      active = (m_mode == M_CRUISE) || (m_mode == M_ACCEL) || (m_mode == M_DECEL);
      m_up = active && (spd < m_target);
      m_dn = active && (spd > m_target);
      if (m_mode == M_OFF) begin
         if (co && !cf && !br && spd >= MIN_SPEED && spd <= MAX_SPEED) begin
            m_mode = M_CRUISE; m_target = spd; m_valid = 1;
         end
      end else if (m_mode == M_STANDBY) begin
         if (cf) begin
            m_mode = M_OFF; m_target = 0; m_valid = 0;
         end else if (co) begin
            m_mode = M_CRUISE;
         end
      end else if (cf) begin
         m_mode = M_OFF; m_target = 0; m_valid = 0;
      end else if (br) begin
         m_mode = M_STANDBY;
      end else if (m_mode == M_CRUISE) begin
         if (ac && !dc)      begin m_mode = M_ACCEL; m_held = 0; end
         else if (dc && !ac) begin m_mode = M_DECEL; m_held = 0; end
      end else begin
         bit held_ok;
         held_ok = (m_mode == M_ACCEL) ? (ac && !dc) : (dc && !ac);
         if (!held_ok) begin
            m_mode = M_CRUISE;
         end else begin
            m_held++;
            if (m_held % TICK_DIV == 0) begin
               if (m_mode == M_ACCEL)
                  m_target = (m_target + STEP > MAX_SPEED) ? MAX_SPEED : m_target + STEP;
               else
                  m_target = (m_target - STEP < MIN_SPEED) ? MIN_SPEED : m_target - STEP;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit co, input bit cf, input bit br,
                        input bit ac, input bit dc, input int spd);
      obs_t e;
      @(negedge clk);
      reset = r; cruise_on = co; cruise_off = cf; brake = br;
      accel = ac; decel = dc; speed = SPEED_W'(spd);
      model_step(r, co, cf, br, ac, dc, spd);
      e.st  = 3'(m_mode);
      e.act = (m_mode == M_CRUISE) || (m_mode == M_ACCEL) || (m_mode == M_DECEL);
      e.tgt = SPEED_W'(m_target);
      e.vld = m_valid;
      e.up  = m_up;
      e.dn  = m_dn;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input int spd);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, spd);
   endtask

   task automatic hold(input int n, input bit ac, input bit dc, input int spd);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, ac, dc, spd);
   endtask

   // Monitor: one observation per clock, compared against the oldest expectation.
   initial begin
      obs_t e, got;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state, cruise_active, target_speed, target_valid, throttle_up, throttle_down};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs cycle %0d: got st=%0d act=%0b tgt=%0d vld=%0b up=%0b dn=%0b, expected st=%0d act=%0b tgt=%0d vld=%0b up=%0b dn=%0b",
                        cyc, got.st, got.act, got.tgt, got.vld, got.up, got.dn,
                        e.st, e.act, e.tgt, e.vld, e.up, e.dn);
            end
         end
      end
   end

   initial begin
      int spd, len, pat;
      bit co, cf, br, ac, dc, r;
      reset = 1'b1; cruise_on = 1'b0; cruise_off = 1'b0; brake = 1'b0;
      accel = 1'b0; decel = 1'b0; speed = '0;

      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      idle(2, 60);

      // Engage at 60, then slower vehicle requests throttle up
      cycle(0, 1, 0, 0, 0, 0, 60);
      idle(3, 55);
      idle(1, 60);

      // Hold accel 13 cycles: steps at entry+4, +8, +12, then release
      hold(13, 1, 0, 60);
      idle(3, 60);

      // Reset while adjusting
      hold(6, 1, 0, 70);
      cycle(1, 0, 0, 0, 1, 0, 70);
      idle(2, 70);

      // Upper and lower saturation
      cycle(0, 1, 0, 0, 0, 0, 119);
      hold(12, 1, 0, 119);
      idle(2, 119);
      cycle(0, 0, 1, 0, 0, 0, 119);
      cycle(0, 1, 0, 0, 0, 0, 46);
      hold(12, 0, 1, 46);
      idle(2, 46);
      cycle(0, 0, 1, 0, 0, 0, 46);

      // Suspend, resume, and cruise_off winning over brake
      cycle(0, 1, 0, 0, 0, 0, 70);
      idle(1, 80);
      cycle(0, 0, 0, 1, 0, 0, 80);
      hold(3, 1, 0, 80);
      cycle(0, 1, 0, 0, 0, 0, 80);
      idle(2, 80);
      cycle(0, 0, 1, 1, 0, 0, 80);
      idle(2, 80);

      // Engage range boundaries and simultaneous buttons
      cycle(0, 1, 0, 0, 0, 0, 30);
      cycle(0, 1, 0, 0, 0, 0, 130);
      cycle(0, 1, 0, 0, 0, 0, 44);
      cycle(0, 1, 0, 0, 0, 0, 121);
      cycle(0, 1, 0, 0, 0, 0, 120);
      cycle(0, 0, 1, 0, 0, 0, 120);
      cycle(0, 1, 0, 0, 0, 0, 45);
      hold(5, 1, 1, 45);
      hold(3, 0, 1, 45);
      cycle(0, 0, 1, 0, 0, 0, 45);

      // Randomized runs of held button patterns with a drifting speed
      spd = 80;
      for (int run = 0; run < 500; run++) begin
         len = int'($urandom_range(1, 14));
         pat = int'($urandom_range(0, 9));
         ac = (pat inside {[0:3]}) || (pat == 8);
         dc = (pat inside {[4:6]}) || (pat == 8);
         for (int k = 0; k < len; k++) begin
            r  = ($urandom_range(0, 999) < 3);
            co = ($urandom_range(0, 99) < 12);
            cf = ($urandom_range(0, 99) < 2);
            br = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 19) == 0)
               spd = int'($urandom_range(20, 140));
            else
               spd = spd + int'($urandom_range(0, 4)) - 2;
            if (spd < 0)   spd = 0;
            if (spd > 255) spd = 255;
            cycle(r, co, cf, br, ac, dc, spd);
         end
      end

      idle(2, 60);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
